// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, redirect/stall/flush, IF/ID latch, sticky illegal-fetch fault.
// Define FETCH_PERF_COUNT_EN to add the FetchCount/RedirectCount outputs.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IfId_Instruction,
    output logic [31:0] IfId_PCPlus4,
    output logic        IfId_Valid,
    output logic        Running,
    output logic        Fault
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] RedirectCount
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        legal;

    assign pc_plus4 = pc + 32'd4;
    assign legal    = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < IMEM_WORDS);

    assign Address = pc;
    assign Running = (state == RUN);
    assign Fault   = (state == FAULT);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            IfId_Instruction <= NOP_WORD;
            IfId_PCPlus4     <= 32'd0;
            IfId_Valid       <= 1'b0;
`ifdef FETCH_PERF_COUNT_EN
            FetchCount       <= 32'd0;
            RedirectCount    <= 32'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state <= legal ? RUN : FAULT;
                end
                RUN: begin
`ifdef FETCH_PERF_COUNT_EN
                    if (RedirectValid)
                        RedirectCount <= RedirectCount + 32'd1;
`endif
                    // Legality of the current PC outranks every control input.
                    if (!legal) begin
                        state            <= FAULT;
                        IfId_Instruction <= NOP_WORD;
                        IfId_Valid       <= 1'b0;
                    end else if (RedirectValid) begin
                        pc               <= RedirectTarget;
                        IfId_Instruction <= NOP_WORD;
                        IfId_Valid       <= 1'b0;
                    end else if (Stall && Flush) begin
                        IfId_Instruction <= NOP_WORD;
                        IfId_Valid       <= 1'b0;
                    end else if (Stall) begin
                        pc <= pc;
                    end else if (Flush) begin
                        pc               <= pc_plus4;
                        IfId_Instruction <= NOP_WORD;
                        IfId_Valid       <= 1'b0;
                    end else begin
                        pc               <= pc_plus4;
                        IfId_Instruction <= Instruction;
                        IfId_PCPlus4     <= pc_plus4;
                        IfId_Valid       <= 1'b1;
`ifdef FETCH_PERF_COUNT_EN
                        FetchCount       <= FetchCount + 32'd1;
`endif
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded random bench for instruction_fetch_unit with a behavioural fetch model.
// Counter outputs are checked when FETCH_PERF_COUNT_EN is defined.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectTarget = 32'd0;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IfId_Instruction;
    logic [31:0] IfId_PCPlus4;
    logic        IfId_Valid;
    logic        Running;
    logic        Fault;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] FetchCount;
    logic [31:0] RedirectCount;
`endif

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(1024),
        .NOP_WORD  (NOP)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Stall           (Stall),
        .Flush           (Flush),
        .RedirectValid   (RedirectValid),
        .RedirectTarget  (RedirectTarget),
        .Address         (Address),
        .Instruction     (Instruction),
        .IfId_Instruction(IfId_Instruction),
        .IfId_PCPlus4    (IfId_PCPlus4),
        .IfId_Valid      (IfId_Valid),
        .Running         (Running),
        .Fault           (Fault)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .FetchCount      (FetchCount),
        .RedirectCount   (RedirectCount)
`endif
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [0:1023];

    always_comb begin
        Instruction = 32'hDEAD_BEEF;
        if (Address[1:0] == 2'b00 && Address[31:12] == 20'd0)
            Instruction = mem[Address[11:2]];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC as a plain number, progress as two flags.
    longint      m_pc;
    bit          m_started;
    bit          m_fault;
    logic [31:0] m_ins;
    logic [31:0] m_p4;
    bit          m_valid;
    logic [31:0] m_fc;
    logic [31:0] m_rc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        valid;
        logic        run;
        logic        fault;
        logic [31:0] fc;
        logic [31:0] rc;
    } exp_t;

    exp_t q[$];

    function automatic bit legal(longint a);
        return (a % 4 == 0) && (a / 4 < 1024);
    endfunction

    task automatic model_reset();
        m_pc      = 0;
        m_started = 0;
        m_fault   = 0;
        m_ins     = NOP;
        m_p4      = 32'd0;
        m_valid   = 0;
        m_fc      = 32'd0;
        m_rc      = 32'd0;
    endtask

    task automatic model_edge(bit st, bit fl, bit rv, logic [31:0] tgt);
        longint nxt;
        nxt = (m_pc + 4) % 64'h1_0000_0000;
        if (m_fault) return;
        if (!m_started) begin
            m_started = 1;
            if (!legal(m_pc)) m_fault = 1;
            return;
        end
        if (rv) m_rc = m_rc + 32'd1;
        if (!legal(m_pc)) begin
            m_fault = 1;
            m_ins   = NOP;
            m_valid = 0;
        end else if (rv) begin
            m_pc    = longint'(tgt);
            m_ins   = NOP;
            m_valid = 0;
        end else if (st && fl) begin
            m_ins   = NOP;
            m_valid = 0;
        end else if (st) begin
            m_valid = m_valid;
        end else if (fl) begin
            m_pc    = nxt;
            m_ins   = NOP;
            m_valid = 0;
        end else begin
            m_ins   = mem[int'(m_pc / 4)];
            m_p4    = 32'(nxt);
            m_valid = 1;
            m_pc    = nxt;
            m_fc    = m_fc + 32'd1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.addr  = 32'(m_pc);
        e.ins   = m_ins;
        e.p4    = m_p4;
        e.valid = m_valid;
        e.run   = m_started && !m_fault;
        e.fault = m_fault;
        e.fc    = m_fc;
        e.rc    = m_rc;
        q.push_back(e);
    endtask

    task automatic step(bit st, bit fl, bit rv, logic [31:0] tgt);
        @(negedge Clk);
        #1;
        Stall          = st;
        Flush          = fl;
        RedirectValid  = rv;
        RedirectTarget = tgt;
        model_edge(st, fl, rv, tgt);
        push_exp();
    endtask

    // Reset is pulled low between edges and checked before any clock arrives.
    task automatic do_reset();
        @(negedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        model_reset();
        chk("rst_addr", Address, 32'd0);
        chk("rst_ins", IfId_Instruction, NOP);
        chk("rst_p4", IfId_PCPlus4, 32'd0);
        chk("rst_valid", {31'd0, IfId_Valid}, 32'd0);
        chk("rst_running", {31'd0, Running}, 32'd0);
        chk("rst_fault", {31'd0, Fault}, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("rst_fc", FetchCount, 32'd0);
        chk("rst_rc", RedirectCount, 32'd0);
`endif
        @(negedge Clk);
        #1;
        Reset          = 1'b1;
        Stall          = 1'b0;
        Flush          = 1'b0;
        RedirectValid  = 1'b0;
        RedirectTarget = 32'd0;
        model_edge(0, 0, 0, 32'd0);
        push_exp();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("addr", Address, e.addr);
                chk("ifid_ins", IfId_Instruction, e.ins);
                chk("ifid_p4", IfId_PCPlus4, e.p4);
                chk("ifid_valid", {31'd0, IfId_Valid}, {31'd0, e.valid});
                chk("running", {31'd0, Running}, {31'd0, e.run});
                chk("fault", {31'd0, Fault}, {31'd0, e.fault});
`ifdef FETCH_PERF_COUNT_EN
                chk("fetch_count", FetchCount, e.fc);
                chk("redirect_count", RedirectCount, e.rc);
`endif
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] tgt;
        bit          st;
        bit          fl;
        bit          rv;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 3);
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        do_reset();

        repeat (4) step(0, 0, 0, 32'd0);
        repeat (3) step(1, 0, 0, 32'd0);
        step(0, 0, 0, 32'd0);
        step(0, 0, 1, 32'd8);
        step(1, 0, 1, 32'h40);
        step(0, 0, 0, 32'd0);
        step(0, 0, 1, 32'd12);
        step(0, 1, 0, 32'd0);
        step(0, 0, 1, 32'd12);
        step(1, 1, 0, 32'd0);
        step(0, 0, 1, 32'hFFC);
        step(0, 0, 0, 32'd0);
        step(0, 0, 1, 32'h1000);
        step(0, 0, 0, 32'd0);
        step(0, 0, 1, 32'h40);
        step(1, 1, 1, 32'h80);
        step(0, 0, 0, 32'd0);
        do_reset();
        step(0, 0, 1, 32'h2);
        step(0, 0, 0, 32'd0);
        step(0, 0, 0, 32'd0);

        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int i = 0; i < 1024; i++) mem[i] = $urandom();
            for (int n = 0; n < 300; n++) begin
                st = ($urandom_range(0, 3) == 0);
                fl = ($urandom_range(0, 5) == 0);
                rv = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 39) == 0)
                    tgt = $urandom();
                else
                    tgt = 32'($urandom_range(0, 1023)) << 2;
                step(st, fl, rv, tgt);
            end
        end

        repeat (3) @(negedge Clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
